// File: rtl/operand_serializer.sv
// operand_serializer
//   Accepts a pair of two's-complement operands and streams them LSB first,
//   one bit of each per cycle, to a downstream bit-serial adder.
//   Sequence per operand pair: IDLE -> CLEAR (one-cycle carry clear) ->
//   SHIFT (WIDTH+EXTEND bits, freezable by pause) -> DONE (one-cycle pulse).
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   in_valid  operand pair offered (sampled only in IDLE)
//   in_ready  high in IDLE only
//   op_a/op_b operands, WIDTH bits, two's complement
//   pause     freezes serialization while high (SHIFT only)
//   a/b       current serial bits of A and B, LSB first
//   enable    advance strobe for the downstream adder
//   clear     one-cycle pulse resetting the downstream carry
//   last      marks the final serial bit
//   done      one-cycle pulse after the final bit
module operand_serializer #(
  parameter int WIDTH  = 8,
  parameter int EXTEND = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             pause,
  output logic             a,
  output logic             b,
  output logic             enable,
  output logic             clear,
  output logic             last,
  output logic             done
);

  localparam int              N        = WIDTH + EXTEND;
  localparam int              CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]   LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr_a, sr_b, sr_a_nxt, sr_b_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             fill_a, fill_b;

  // Right shifts re-insert the MSB, so the top bit always holds the
  // operand's original sign for the optional extension bit.
  assign fill_a = (EXTEND != 0) ? sr_a[WIDTH-1] : 1'b0;
  assign fill_b = (EXTEND != 0) ? sr_b[WIDTH-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr_a  <= '0;
      sr_b  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr_a  <= sr_a_nxt;
      sr_b  <= sr_b_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_a_nxt  = sr_a;
    sr_b_nxt  = sr_b;
    in_ready  = 1'b0;
    a         = 1'b0;
    b         = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    last      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_a_nxt  = op_a;
          sr_b_nxt  = op_b;
          cnt_nxt   = '0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        clear     = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        a = sr_a[0];
        b = sr_b[0];
        if (!pause) begin
          enable   = 1'b1;
          sr_a_nxt = {fill_a, sr_a[WIDTH-1:1]};
          sr_b_nxt = {fill_b, sr_b[WIDTH-1:1]};
          if (cnt == LAST_CNT) begin
            last      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
